// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern engine: pattern mode codes and FSM states.
package led_pattern_pkg;

  localparam logic [1:0] MODE_BLINK  = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/led_pattern_gen_tick_div.sv
// Generic prescaler: tick is high on the last of every DIV enabled cycles.
module tick_div #(
  parameter int DIV = 2500000
) (
  input  logic ck,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_reg;

  assign tick = en && (count_reg == CNT_MAX);

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: blink/chase/bounce/fill on a WIDTH-bit bank, stepped by tick_div,
// with a registered one-cycle frame_done at the end of each pattern period.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DIV   = 2500000
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] leds,
  output logic             frame_done
);

  localparam int POS_W  = $clog2(WIDTH);
  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);

  state_t             state_reg, state_next;
  logic [1:0]         mode_q_reg, mode_q_next;
  logic [POS_W-1:0]   pos_reg, pos_next;
  logic               up_reg, up_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic [WIDTH-1:0]   leds_reg, leds_next;
  logic               frame_reg, frame_next;

  logic               tick;
  logic               step;
  logic [WIDTH-1:0]   onehot;
  logic [WIDTH-1:0]   fill_mask;

  tick_div #(.DIV(DIV)) u_tick_div (
    .ck   (ck),
    .rs   (rs),
    .en   (en && (state_reg == ST_RUN)),
    .clr  (state_reg == ST_LOAD),
    .tick (tick)
  );

  // A pending mode change wins over a coincident tick: no step, no frame_done.
  assign step = (state_reg == ST_RUN) && (mode == mode_q_reg) && tick;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign onehot[gi]    = (pos_next == POS_W'(gi));
      assign fill_mask[gi] = (fill_next > FILL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    mode_q_next = mode_q_reg;
    pos_next    = pos_reg;
    up_next     = up_reg;
    fill_next   = fill_reg;
    frame_next  = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        state_next  = ST_RUN;
        mode_q_next = mode;
        up_next     = 1'b1;
        fill_next   = '0;
        pos_next    = ((mode == MODE_CHASE) && dir) ? POS_MAX : '0;
      end
      default: begin
        if (mode != mode_q_reg) begin
          state_next = ST_LOAD;
        end else if (step) begin
          case (mode_q_reg)
            MODE_BLINK: frame_next = &leds_reg;
            MODE_CHASE: begin
              if (!dir) begin
                pos_next   = (pos_reg == POS_MAX) ? '0 : pos_reg + 1'b1;
                frame_next = (pos_reg == POS_MAX);
              end else begin
                pos_next   = (pos_reg == '0) ? POS_MAX : pos_reg - 1'b1;
                frame_next = (pos_reg == '0);
              end
            end
            MODE_BOUNCE: begin
              // Reverse as soon as an endpoint is reached so each end is lit for one tick.
              if (up_reg) begin
                pos_next = pos_reg + 1'b1;
                up_next  = (pos_next != POS_MAX);
              end else begin
                pos_next   = pos_reg - 1'b1;
                up_next    = (pos_next == '0);
                frame_next = (pos_next == '0);
              end
            end
            default: begin
              fill_next  = (fill_reg == FILL_MAX) ? '0 : fill_reg + 1'b1;
              frame_next = (fill_reg == FILL_MAX);
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    leds_next = leds_reg;
    if (state_reg == ST_LOAD) begin
      case (mode)
        MODE_CHASE, MODE_BOUNCE: leds_next = onehot;
        default:                 leds_next = '0;
      endcase
    end else if (step) begin
      case (mode_q_reg)
        MODE_BLINK:              leds_next = ~leds_reg;
        MODE_CHASE, MODE_BOUNCE: leds_next = onehot;
        default:                 leds_next = fill_mask;
      endcase
    end
  end

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      state_reg  <= ST_LOAD;
      mode_q_reg <= MODE_BLINK;
      pos_reg    <= '0;
      up_reg     <= 1'b1;
      fill_reg   <= '0;
      leds_reg   <= '0;
      frame_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_q_reg <= mode_q_next;
      pos_reg    <= pos_next;
      up_reg     <= up_next;
      fill_reg   <= fill_next;
      leds_reg   <= leds_next;
      frame_reg  <= frame_next;
    end
  end

  assign leds       = leds_reg;
  assign frame_done = frame_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed and random stimulus for led_pattern_gen (WIDTH=4, DIV=3) checked every cycle
// against an index-based behavioural model of the four patterns.
module tb_led_pattern_gen;

  localparam int W = 4;
  localparam int D = 3;

  logic         ck = 1'b0;
  logic         rs;
  logic         en;
  logic [1:0]   mode;
  logic         dir;
  logic [W-1:0] leds;
  logic         frame_done;

  int total = 0;
  int bad   = 0;
  int fcnt  = 0;
  int ncyc  = 0;

  // Model: latched mode, enabled-cycle count, step index k within the period, chase position.
  int m_mode, m_k, m_pos, m_cnt;
  bit m_load, m_frame;

  always #5 ck = ~ck;

  led_pattern_gen #(.WIDTH(W), .DIV(D)) dut (
    .ck         (ck),
    .rs         (rs),
    .en         (en),
    .mode       (mode),
    .dir        (dir),
    .leds       (leds),
    .frame_done (frame_done)
  );

  function automatic logic [W-1:0] exp_leds();
    int b;
    case (m_mode)
      0: return (m_k % 2 == 1) ? {W{1'b1}} : '0;
      1: return W'(1) << m_pos;
      2: begin
        b = (m_k <= W - 1) ? m_k : 2 * (W - 1) - m_k;
        return W'(1) << b;
      end
      default: return W'((1 << m_k) - 1);
    endcase
  endfunction

  function automatic int period(int md);
    case (md)
      0:       return 2;
      2:       return 2 * (W - 1);
      default: return W + 1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_pos = 0; m_cnt = 0; m_load = 1'b1; m_frame = 1'b0;
  endtask

  task automatic model_edge();
    m_frame = 1'b0;
    if (rs) begin
      model_reset();
    end else if (m_load) begin
      m_mode = int'(mode); m_k = 0; m_cnt = 0; m_load = 1'b0;
      m_pos  = (mode == 2'd1 && dir) ? W - 1 : 0;
    end else if (int'(mode) != m_mode) begin
      m_load = 1'b1;
    end else if (en) begin
      m_cnt++;
      if (m_cnt == D) begin
        m_cnt = 0;
        if (m_mode == 1) begin
          if (!dir) begin
            m_frame = (m_pos == W - 1);
            m_pos   = (m_pos + 1) % W;
          end else begin
            m_frame = (m_pos == 0);
            m_pos   = (m_pos + W - 1) % W;
          end
        end else begin
          m_k     = (m_k + 1) % period(m_mode);
          m_frame = (m_k == 0);
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk1(string tag, logic got, logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge ck);
    #1;
    ncyc++;
    if (frame_done === 1'b1) fcnt++;
    $display("cyc %0d rs=%b en=%b mode=%0d dir=%b leds=%b fd=%b", ncyc, rs, en, mode, dir,
             leds, frame_done);
    chk("leds", leds, exp_leds());
    chk1("frame_done", frame_done, m_frame);
  endtask

  task automatic async_reset();
    #2 rs = 1'b1;
    #1;
    chk("async_rst_leds", leds, '0);
    chk1("async_rst_frame", frame_done, 1'b0);
    model_reset();
    cycle();
    rs = 1'b0;
  endtask

  task automatic wait_chase_pos(int p);
    int n;
    n = 0;
    while (!(m_mode == 1 && !m_load && int'(mode) == 1 && m_pos == p) && n < 60) begin
      cycle();
      n++;
    end
    total++;
    assert (n < 60) else begin
      bad++;
      $error("FAIL wait_chase_pos: observed=%0d cycles expected=<60", n);
    end
  endtask

  initial begin
    int n;
    rs = 1'b1; en = 1'b1; mode = 2'd1; dir = 1'b0;
    model_reset();
    cycle();
    cycle();
    chk("rst_leds", leds, '0);
    chk1("rst_frame", frame_done, 1'b0);
    rs = 1'b0;

    // Reset mid-run from CHASE 0100, then reload CHASE toward MSB.
    wait_chase_pos(2);
    chk("chase_0100", leds, 4'b0100);
    async_reset();
    cycle();
    chk("reload_0001", leds, 4'b0001);

    // FILL: exactly one frame pulse in a window covering one period.
    $display("scenario fill");
    mode = 2'd3; fcnt = 0;
    repeat (18) cycle();
    total++;
    assert (fcnt == 1) else begin
      bad++;
      $error("FAIL fill_frames: observed=%0d expected=1", fcnt);
    end

    $display("scenario bounce");
    mode = 2'd2; fcnt = 0;
    repeat (22) cycle();
    total++;
    assert (fcnt == 1) else begin
      bad++;
      $error("FAIL bounce_frames: observed=%0d expected=1", fcnt);
    end

    $display("scenario chase dir=1");
    mode = 2'd1; dir = 1'b1; fcnt = 0;
    repeat (16) cycle();
    total++;
    assert (fcnt == 1) else begin
      bad++;
      $error("FAIL chase_frames: observed=%0d expected=1", fcnt);
    end
    wait_chase_pos(1);
    chk("chase_0010", leds, 4'b0010);
    dir = 1'b0;
    n = 0;
    while (m_pos == 1 && n < 4) begin
      cycle();
      n++;
    end
    chk("chase_dir_flip", leds, 4'b0100);

    $display("scenario enable hold");
    mode = 2'd0;
    n = 0;
    while (!(m_mode == 0 && !m_load && m_cnt == 1) && n < 20) begin
      cycle();
      n++;
    end
    en = 1'b0;
    repeat (10) cycle();
    en = 1'b1;
    repeat (4) cycle();

    $display("scenario mode change");
    mode = 2'd1; dir = 1'b0;
    wait_chase_pos(2);
    mode = 2'd0;
    cycle();
    chk("mc_hold", leds, 4'b0100);
    cycle();
    chk("mc_load", leds, 4'b0000);
    repeat (3) cycle();
    chk("mc_blink_on", leds, 4'b1111);

    $display("scenario random");
    repeat (400) begin
      if ($urandom_range(99) == 0) begin
        async_reset();
      end else begin
        en = ($urandom_range(7) != 0);
        if ($urandom_range(29) == 0) mode = 2'($urandom_range(3));
        if ($urandom_range(9) == 0) dir = ~dir;
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
